// File: rtl/ddr4_mc_ecc_merge_if.sv
// Bundle for the RMW write-merge path: buffer fill strobe, write beat request,
// returned buffer data and the merged word handed to the ECC encoder.
interface ddr4_mc_ecc_merge_if #(
  parameter int DATA_BUF_ADDR_WIDTH   = 5,
  parameter int DATA_BUF_OFFSET_WIDTH = 1,
  parameter int DATA_WIDTH            = 64,
  parameter int nCK_PER_CLK           = 4
) ();
  localparam int W  = 2 * nCK_PER_CLK * DATA_WIDTH;
  localparam int NB = W / 8;

  logic                             wr_ecc_buf;
  logic [DATA_BUF_ADDR_WIDTH-1:0]   rd_data_addr;
  logic [DATA_BUF_OFFSET_WIDTH-1:0] rd_data_offset;
  logic                             wr_data_en;
  logic                             wr_data_rmw;
  logic [DATA_BUF_ADDR_WIDTH-1:0]   wr_data_addr;
  logic [DATA_BUF_OFFSET_WIDTH-1:0] wr_data_offset;
  logic [W-1:0]                     wr_data;
  logic [NB-1:0]                    wr_data_mask;
  logic [W-1:0]                     rd_merge_data;
  logic                             merged_valid;
  logic [W-1:0]                     merged_data;
  logic                             merged_rmw;
  logic                             rmw_underrun;
  logic [7:0]                       underrun_cnt;
`ifdef DDR4_MC_ECC_MERGE_PARITY_EN
  logic [NB-1:0]                    merged_par;
`endif

  modport master (
    output wr_ecc_buf, rd_data_addr, rd_data_offset,
    output wr_data_en, wr_data_rmw, wr_data_addr, wr_data_offset,
    output wr_data, wr_data_mask, rd_merge_data,
`ifdef DDR4_MC_ECC_MERGE_PARITY_EN
    input  merged_par,
`endif
    input  merged_valid, merged_data, merged_rmw, rmw_underrun, underrun_cnt
  );

  modport slave (
    input  wr_ecc_buf, rd_data_addr, rd_data_offset,
    input  wr_data_en, wr_data_rmw, wr_data_addr, wr_data_offset,
    input  wr_data, wr_data_mask, rd_merge_data,
`ifdef DDR4_MC_ECC_MERGE_PARITY_EN
    output merged_par,
`endif
    output merged_valid, merged_data, merged_rmw, rmw_underrun, underrun_cnt
  );
endinterface

// File: rtl/ddr4_mc_ecc_merge.sv
// RMW write merge: tracks filled read-merge slots, merges buffer data under byte
// mask with a fixed 2-cycle latency. Optional byte parity: DDR4_MC_ECC_MERGE_PARITY_EN.
module ddr4_mc_ecc_merge #(
  parameter int DATA_BUF_ADDR_WIDTH   = 5,
  parameter int DATA_BUF_OFFSET_WIDTH = 1,
  parameter int DATA_WIDTH            = 64,
  parameter int nCK_PER_CLK           = 4,
  parameter int TCQ                   = 100
) (
  input logic                clk,
  input logic                rst_n,
  ddr4_mc_ecc_merge_if.slave bus
);
  localparam int W  = 2 * nCK_PER_CLK * DATA_WIDTH;
  localparam int NB = W / 8;
  localparam int unused_tcq = TCQ;

  function automatic logic [NB-1:0] byte_parity(input logic [W-1:0] d);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int b = 0; b < NB; b++) begin
      p[b] = ^d[b*8 +: 8];
    end
    return p;
  endfunction

  logic [3:0]    fill_addr_s;
  logic [3:0]    wr_addr_s;
  logic [4:0]    fill_idx_s;
  logic [4:0]    wr_idx_s;
  logic [31:0]   set_s;
  logic [31:0]   clr_s;
  logic          hit_s;
  logic [31:0]   valid_map_r;
  logic          s1_valid_r;
  logic          s1_rmw_r;
  logic          s1_hit_r;
  logic [W-1:0]  s1_data_r;
  logic [NB-1:0] s1_mask_r;
  logic [W-1:0]  merged_s;
  logic          underrun_s;
  logic          merged_valid_r;
  logic [W-1:0]  merged_data_r;
  logic          merged_rmw_r;
  logic          rmw_underrun_r;
  logic [7:0]    underrun_cnt_r;
  logic          unused_s;

  // Only the low four address bits select a slot; tag bits above are dropped.
  if (DATA_BUF_ADDR_WIDTH >= 4) begin : g_addr_wide
    assign fill_addr_s = bus.rd_data_addr[3:0];
    assign wr_addr_s   = bus.wr_data_addr[3:0];
  end else begin : g_addr_narrow
    assign fill_addr_s = {{(4-DATA_BUF_ADDR_WIDTH){1'b0}}, bus.rd_data_addr};
    assign wr_addr_s   = {{(4-DATA_BUF_ADDR_WIDTH){1'b0}}, bus.wr_data_addr};
  end

  assign fill_idx_s = {fill_addr_s, bus.rd_data_offset[0]};
  assign wr_idx_s   = {wr_addr_s, bus.wr_data_offset[0]};
  assign hit_s      = valid_map_r[wr_idx_s];
  assign unused_s   = ^{bus.rd_data_addr, bus.wr_data_addr,
                        bus.rd_data_offset, bus.wr_data_offset};

  // One-hot fill and consume vectors for the slot map update.
  always_comb begin
    set_s = 32'd0;
    clr_s = 32'd0;
    if (bus.wr_ecc_buf) begin
      set_s[fill_idx_s] = 1'b1;
    end else begin
      set_s = 32'd0;
    end
    if (bus.wr_data_en && bus.wr_data_rmw) begin
      clr_s[wr_idx_s] = 1'b1;
    end else begin
      clr_s = 32'd0;
    end
  end

  // Slot map: set is applied after clear so a same-cycle fill keeps the slot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_map_r <= 32'd0;
    end else begin
      valid_map_r <= (valid_map_r & ~clr_s) | set_s;
    end
  end

  // Stage 1 capture of the write beat and its pre-edge hit status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_rmw_r   <= 1'b0;
      s1_hit_r   <= 1'b0;
      s1_data_r  <= {W{1'b0}};
      s1_mask_r  <= {NB{1'b0}};
    end else begin
      s1_valid_r <= bus.wr_data_en;
      if (bus.wr_data_en) begin
        s1_rmw_r  <= bus.wr_data_rmw;
        s1_hit_r  <= hit_s;
        s1_data_r <= bus.wr_data;
        s1_mask_r <= bus.wr_data_mask;
      end
    end
  end

  // Byte merge: buffer data arrives now, one cycle after the beat's address.
  always_comb begin
    merged_s = s1_data_r;
    for (int b = 0; b < NB; b++) begin
      if (s1_rmw_r && s1_mask_r[b]) begin
        merged_s[b*8 +: 8] = bus.rd_merge_data[b*8 +: 8];
      end else begin
        merged_s[b*8 +: 8] = s1_data_r[b*8 +: 8];
      end
    end
  end

  assign underrun_s = s1_valid_r & s1_rmw_r & ~s1_hit_r;

  // Output stage; merged word holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merged_valid_r <= 1'b0;
      merged_data_r  <= {W{1'b0}};
      merged_rmw_r   <= 1'b0;
      rmw_underrun_r <= 1'b0;
      underrun_cnt_r <= 8'd0;
    end else begin
      merged_valid_r <= s1_valid_r;
      rmw_underrun_r <= underrun_s;
      if (s1_valid_r) begin
        merged_data_r <= merged_s;
        merged_rmw_r  <= s1_rmw_r;
      end
      if (underrun_s && (underrun_cnt_r != 8'hFF)) begin
        underrun_cnt_r <= underrun_cnt_r + 8'd1;
      end
    end
  end

`ifdef DDR4_MC_ECC_MERGE_PARITY_EN
  logic [NB-1:0] merged_par_r;

  // Parity registered alongside the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merged_par_r <= {NB{1'b0}};
    end else if (s1_valid_r) begin
      merged_par_r <= byte_parity(merged_s);
    end
  end

  assign bus.merged_par = merged_par_r;
`endif

  assign bus.merged_valid = merged_valid_r;
  assign bus.merged_data  = merged_data_r;
  assign bus.merged_rmw   = merged_rmw_r;
  assign bus.rmw_underrun = rmw_underrun_r;
  assign bus.underrun_cnt = underrun_cnt_r;

endmodule

// File: tb/tb_ddr4_mc_ecc_merge.sv
// Bench for ddr4_mc_ecc_merge: directed scenarios plus random traffic, checked
// every cycle against a slot-map / beat-queue reference model.
module tb_ddr4_mc_ecc_merge;
  localparam int AW = 5;
  localparam int OW = 1;
  localparam int DW = 64;
  localparam int NCK = 4;
  localparam int W = 2 * NCK * DW;
  localparam int NB = W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr4_mc_ecc_merge_if #(.DATA_BUF_ADDR_WIDTH(AW), .DATA_BUF_OFFSET_WIDTH(OW),
                         .DATA_WIDTH(DW), .nCK_PER_CLK(NCK)) bus ();

  ddr4_mc_ecc_merge #(.DATA_BUF_ADDR_WIDTH(AW), .DATA_BUF_OFFSET_WIDTH(OW),
                      .DATA_WIDTH(DW), .nCK_PER_CLK(NCK), .TCQ(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // reference model state
  bit            m_map [32];
  bit            p_v, p_rmw, p_hit;
  logic [W-1:0]  p_data;
  logic [NB-1:0] p_mask;
  logic          e_valid, e_rmw, e_under;
  logic [W-1:0]  e_data;
  logic [NB-1:0] e_par;
  int            e_cnt;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int slot_of(int addr, int off);
    return (addr % 16) * 2 + (off % 2);
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    foreach (m_map[i]) m_map[i] = 1'b0;
    p_v = 1'b0; p_rmw = 1'b0; p_hit = 1'b0; p_data = '0; p_mask = '0;
    e_valid = 1'b0; e_rmw = 1'b0; e_under = 1'b0; e_data = '0; e_par = '0;
    e_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("merged_valid", W'(bus.merged_valid), W'(e_valid));
    chk("merged_data", bus.merged_data, e_data);
    chk("merged_rmw", W'(bus.merged_rmw), W'(e_rmw));
    chk("rmw_underrun", W'(bus.rmw_underrun), W'(e_under));
    chk("underrun_cnt", W'(bus.underrun_cnt), W'(e_cnt));
`ifdef DDR4_MC_ECC_MERGE_PARITY_EN
    chk("merged_par", W'(bus.merged_par), W'(e_par));
`endif
  endtask

  task automatic idle();
    bus.wr_ecc_buf     = 1'b0;
    bus.rd_data_addr   = AW'($urandom);
    bus.rd_data_offset = OW'($urandom);
    bus.wr_data_en     = 1'b0;
    bus.wr_data_rmw    = 1'($urandom);
    bus.wr_data_addr   = AW'($urandom);
    bus.wr_data_offset = OW'($urandom);
    bus.wr_data        = rand_word();
    bus.wr_data_mask   = {$urandom, $urandom};
    bus.rd_merge_data  = rand_word();
  endtask

  task automatic set_beat(int slot, bit rmw);
    bus.wr_data_en     = 1'b1;
    bus.wr_data_rmw    = rmw;
    bus.wr_data_addr   = AW'((slot / 2) + 16 * ($urandom % 2));
    bus.wr_data_offset = OW'(slot % 2);
  endtask

  task automatic set_fill(int slot);
    bus.wr_ecc_buf     = 1'b1;
    bus.rd_data_addr   = AW'((slot / 2) + 16 * ($urandom % 2));
    bus.rd_data_offset = OW'(slot % 2);
  endtask

  // One clock: model both pipeline stages from the current inputs, then check.
  task automatic step();
    logic [W-1:0] mrg;
    int s;
    bit n_v, n_rmw, n_hit;
    logic [W-1:0] n_data;
    logic [NB-1:0] n_mask;
    mrg = p_data;
    for (int b = 0; b < NB; b++)
      if (p_rmw && p_mask[b]) mrg[b*8 +: 8] = bus.rd_merge_data[b*8 +: 8];
    s = slot_of(int'(bus.wr_data_addr), int'(bus.wr_data_offset));
    n_v = bus.wr_data_en; n_rmw = bus.wr_data_rmw; n_hit = m_map[s];
    n_data = bus.wr_data; n_mask = bus.wr_data_mask;
    if (bus.wr_data_en && bus.wr_data_rmw) m_map[s] = 1'b0;
    if (bus.wr_ecc_buf)
      m_map[slot_of(int'(bus.rd_data_addr), int'(bus.rd_data_offset))] = 1'b1;
    @(posedge clk);
    e_valid = p_v;
    e_under = p_v && p_rmw && !p_hit;
    if (p_v) begin
      e_data = mrg;
      e_rmw = p_rmw;
      for (int b = 0; b < NB; b++) e_par[b] = ^mrg[b*8 +: 8];
    end
    if (e_under && e_cnt < 255) e_cnt++;
    p_v = n_v;
    if (n_v) begin
      p_rmw = n_rmw; p_hit = n_hit; p_data = n_data; p_mask = n_mask;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_phase(int n);
    rst_n = 1'b0;
    reset_model();
    for (int i = 0; i < n; i++) begin
      idle();
      bus.wr_data_en = 1'($urandom);
      bus.wr_ecc_buf = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_w;
    logic [W-1:0] full_w;
    int vcount, first_v, last_v;

    idle();
    reset_model();
    @(negedge clk);

    // reset holds everything at zero, and stays so until a beat arrives
    reset_phase(4);
    step();
    step();

    // underrun on never-filled slot 9
    idle(); set_beat(9, 1'b1); step();
    idle(); step();
    chk("uf9_pulse", W'(bus.rmw_underrun), W'(1'b1));
    chk("uf9_cnt", W'(bus.underrun_cnt), W'(8'd1));
    idle(); step();
    chk("uf9_pulse_end", W'(bus.rmw_underrun), W'(1'b0));

    // partial write to filled slot 5
    idle(); set_fill(5); step();
    idle(); set_beat(5, 1'b1);
    bus.wr_data = {NB{8'h55}};
    bus.wr_data_mask = 64'h0000_0000_0000_000F;
    step();
    idle(); bus.rd_merge_data = {NB{8'hAA}}; step();
    exp_w = {NB{8'h55}};
    exp_w[31:0] = 32'hAAAA_AAAA;
    chk("pw_data", bus.merged_data, exp_w);
    chk("pw_rmw", W'(bus.merged_rmw), W'(1'b1));
    chk("pw_under", W'(bus.rmw_underrun), W'(1'b0));
    idle(); set_beat(5, 1'b1); step();
    idle(); step();
    chk("pw_slot_cleared", W'(bus.rmw_underrun), W'(1'b1));
    chk("pw_cnt", W'(bus.underrun_cnt), W'(8'd2));

    // full write ignores mask and leaves the slot map alone
    idle(); set_fill(6); step();
    idle(); set_beat(6, 1'b0);
    full_w = rand_word();
    bus.wr_data = full_w;
    bus.wr_data_mask = {NB{1'b1}};
    step();
    idle(); step();
    chk("fw_data", bus.merged_data, full_w);
    chk("fw_rmw", W'(bus.merged_rmw), W'(1'b0));
    chk("fw_under", W'(bus.rmw_underrun), W'(1'b0));
    idle(); set_beat(6, 1'b1); step();
    idle(); step();
    chk("fw_map_kept", W'(bus.rmw_underrun), W'(1'b0));

    // same-slot fill and consume: set wins
    idle(); set_fill(3); step();
    idle(); set_fill(3); set_beat(3, 1'b1); step();
    idle(); step();
    chk("ss_hit", W'(bus.rmw_underrun), W'(1'b0));
    idle(); set_beat(3, 1'b1); step();
    idle(); step();
    chk("ss_still_valid", W'(bus.rmw_underrun), W'(1'b0));

    // back-to-back RMW beats on slots 0-7
    for (int s = 0; s < 8; s++) begin
      idle(); set_fill(s); step();
    end
    vcount = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 11; i++) begin
      idle();
      if (i < 8) set_beat(i, 1'b1);
      step();
      if (bus.merged_valid === 1'b1) begin
        vcount++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    chk("b2b_count", W'(vcount), W'(8));
    chk("b2b_first", W'(first_v), W'(1));
    chk("b2b_contig", W'(last_v - first_v + 1), W'(8));

    // random traffic
    for (int i = 0; i < 300; i++) begin
      idle();
      bus.wr_ecc_buf = 1'($urandom);
      bus.wr_data_en = ($urandom % 4) != 0;
      step();
    end

    // reset in the middle of traffic discards in-flight beats
    idle(); set_beat(7, 1'b1); step();
    idle(); set_beat(8, 1'b0); step();
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs();
    reset_phase(3);
    step();
    step();
    chk("mid_rst_quiet", W'(bus.merged_valid), W'(1'b0));

    // underrun counter saturates
    for (int i = 0; i < 300; i++) begin
      idle(); set_beat(9, 1'b1); step();
    end
    idle(); step();
    idle(); step();
    chk("cnt_saturate", W'(bus.underrun_cnt), W'(8'd255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
